// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Address map constants, register offsets, STATUS bit
//                positions and the MMIO register decoder for mmio_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  // Region bases
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

  // MMIO register byte offsets
  localparam logic [4:0] OFF_TXDATA      = 5'h00;
  localparam logic [4:0] OFF_STATUS      = 5'h04;
  localparam logic [4:0] OFF_MTIME_LO    = 5'h08;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h0C;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h10;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h14;

  // STATUS register bit positions
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_CNT_LSB   = 4;

  typedef enum logic [2:0] {
    REG_NONE        = 3'd0,
    REG_TXDATA      = 3'd1,
    REG_STATUS      = 3'd2,
    REG_MTIME_LO    = 3'd3,
    REG_MTIME_HI    = 3'd4,
    REG_MTIMECMP_LO = 3'd5,
    REG_MTIMECMP_HI = 3'd6
  } reg_e;

  // Map a byte address onto an MMIO register; the two LSBs never matter.
  function automatic reg_e decode_reg(input logic [31:0] addr);
    reg_e r;
    r = REG_NONE;
    if (addr[31:5] == MMIO_BASE[31:5]) begin
      case ({addr[4:2], 2'b00})
        OFF_TXDATA:      r = REG_TXDATA;
        OFF_STATUS:      r = REG_STATUS;
        OFF_MTIME_LO:    r = REG_MTIME_LO;
        OFF_MTIME_HI:    r = REG_MTIME_HI;
        OFF_MTIMECMP_LO: r = REG_MTIMECMP_LO;
        OFF_MTIMECMP_HI: r = REG_MTIMECMP_HI;
        default:         r = REG_NONE;
      endcase
    end
    return r;
  endfunction

  // FIFO occupancy as shown in STATUS[7:4]: clamps at 15 for deep FIFOs.
  function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
    return (cnt > 32'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_responder_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Byte FIFO feeding the TX stream. A push while full is only
//                accepted if a pop frees a slot in the same cycle; otherwise
//                it is dropped and flagged on 'drop'.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop_ready,
  output logic [7:0]                 head_data,
  output logic                       head_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          pop;
  logic          push_ok;

  assign empty      = (cnt == '0);
  assign full       = (cnt == CW'(DEPTH));
  assign pop        = !empty && pop_ready;
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign head_valid = !empty;
  assign head_data  = empty ? 8'h00 : mem[rd_ptr];
  assign count      = cnt;

  // Pointer and occupancy tracking; power-of-two depth makes pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array is never reset; stale slots are hidden by 'empty'.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_responder
//  Description : Single-port data-side responder: word RAM plus MMIO block
//                with a TX byte FIFO, STATUS register and an optional 64-bit
//                machine timer. Loads are combinational, stores commit on the
//                rising clock edge.
//  Config      : define MMIO_TIMER_EN to build the mtime/mtimecmp timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_we,
  input  logic        data_re,
  output logic [31:0] data_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(TX_DEPTH) + 1;

  logic [31:0]       ram [RAM_WORDS];
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  reg_e              sel;
  logic              store_en;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic              ovf_clear;
  logic [31:0]       status_word;
  logic [31:0]       rd_mux;
  logic              unused_addr_lsbs;

  // Word-granular decode: byte lanes within a word are ignored.
  assign unused_addr_lsbs = ^data_addr[1:0];
  assign ram_hit   = ({2'b00, data_addr[31:2]} < 32'(RAM_WORDS));
  assign ram_idx   = data_addr[RAM_AW+1:2];
  assign sel       = decode_reg(data_addr);
  assign store_en  = data_we && !rst;
  assign fifo_push = store_en && (sel == REG_TXDATA);
  assign ovf_clear = store_en && (sel == REG_STATUS) && data_wdata[STATUS_OVF_BIT];

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (data_wdata[7:0]),
    .pop_ready  (tx_ready),
    .head_data  (tx_data),
    .head_valid (tx_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .drop       (fifo_drop)
  );

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (store_en && ram_hit) ram[ram_idx] <= data_wdata;
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst)            overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

  always_comb begin
    status_word = 32'h0;
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;
    status_word[STATUS_OVF_BIT]   = overflow;
    status_word[STATUS_CNT_LSB +: 4] = sat_count4(32'(fifo_count));
  end

`ifdef MMIO_TIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        irq_q;

  // Free-running timer; a write to either mtime half suppresses the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= 64'h0;
      mtimecmp <= '1;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= (mtime >= mtimecmp);
      if (data_we && sel == REG_MTIME_LO)      mtime <= {mtime[63:32], data_wdata};
      else if (data_we && sel == REG_MTIME_HI) mtime <= {data_wdata, mtime[31:0]};
      else                                     mtime <= mtime + 64'd1;
      if (data_we && sel == REG_MTIMECMP_LO)   mtimecmp[31:0]  <= data_wdata;
      if (data_we && sel == REG_MTIMECMP_HI)   mtimecmp[63:32] <= data_wdata;
    end
  end

  assign timer_irq = irq_q;
`else
  assign timer_irq = 1'b0;
`endif

  // Combinational load mux; registers are read before any same-cycle store.
  always_comb begin
    rd_mux = 32'h0;
    if (ram_hit) begin
      rd_mux = ram[ram_idx];
    end else begin
      case (sel)
        REG_STATUS:      rd_mux = status_word;
`ifdef MMIO_TIMER_EN
        REG_MTIME_LO:    rd_mux = mtime[31:0];
        REG_MTIME_HI:    rd_mux = mtime[63:32];
        REG_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
        REG_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
`endif
        default:         rd_mux = 32'h0;
      endcase
    end
    data_rdata = data_re ? rd_mux : 32'h0;
  end

endmodule
`default_nettype wire
